// File: rtl/jk_cmd_driver_if.sv
// Command handshake bundle between a command source and jk_cmd_driver.
// The master offers {j,k}-encoded commands; the slave answers with cmd_ready.
interface jk_cmd_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/jk_cmd_driver.sv
// Queues HOLD/RESET/SET/TOGGLE commands and plays each onto a JK flip-flop as a
// one-cycle drive followed by a settle cycle. Optional q checker: JK_CHECK_EN.
module jk_cmd_driver #(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    jk_cmd_driver_if.slave   cmd_if,
    output logic             j,
    output logic             k,
    output logic             ff_reset_,
    input  logic             q_in,
    output logic             busy,
    output logic [4:0]       count,
    output logic             mismatch
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [1:0]      mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [4:0]      count_r;
    logic [4:0]      count_nxt_s;
    logic            j_r;
    logic            k_r;
    logic            ff_reset_r;
    logic            busy_r;
    logic            push_s;
    logic            pop_s;
    logic            empty_s;

    assign empty_s          = (count_r == 5'd0);
    assign cmd_if.cmd_ready = (count_r != 5'(DEPTH));
    assign push_s           = cmd_if.cmd_valid && cmd_if.cmd_ready && !reset;

    // Next-state logic: a pop happens whenever the sequencer is free to start a slot.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = DRIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRIVE: begin
                state_nxt_s = SETTLE;
            end
            SETTLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = DRIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 5'd1;
            2'b01:   count_nxt_s = count_r - 5'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_if.cmd;
        end
    end

    // Sequencer state, pointers and registered flip-flop drive.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= 5'd0;
            j_r        <= 1'b0;
            k_r        <= 1'b0;
            ff_reset_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            ff_reset_r <= 1'b1;
            busy_r     <= (state_nxt_s != IDLE) || (count_nxt_s != 5'd0);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
                {j_r, k_r} <= mem_r[rd_ptr_r];
            end else begin
                {j_r, k_r} <= 2'b00;
            end
        end
    end

    assign j         = j_r;
    assign k         = k_r;
    assign ff_reset_ = ff_reset_r;
    assign busy      = busy_r;
    assign count     = count_r;

`ifdef JK_CHECK_EN
    logic pred_r;
    logic mismatch_r;

    // Shadow the flip-flop: the command on j/k during DRIVE lands at the edge ending it.
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_r     <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            if (state_r == DRIVE) begin
                case ({j_r, k_r})
                    2'b01:   pred_r <= 1'b0;
                    2'b10:   pred_r <= 1'b1;
                    2'b11:   pred_r <= ~pred_r;
                    default: pred_r <= pred_r;
                endcase
            end else begin
                pred_r <= pred_r;
            end
            if ((state_r == SETTLE) && (q_in != pred_r)) begin
                mismatch_r <= 1'b1;
            end else begin
                mismatch_r <= mismatch_r;
            end
        end
    end

    assign mismatch = mismatch_r;
`else
    logic unused_q_s;
    assign unused_q_s = q_in;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flip-flop on j/k/ff_reset_.
module tb_jk_cmd_driver;

`ifdef JK_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       j;
    logic       k;
    logic       ff_reset_;
    logic       q_in;
    logic       busy;
    logic [4:0] count;
    logic       mismatch;
    logic       ff_q;
    logic       force_q0;
    int         n_pass;
    int         n_total;

    jk_cmd_driver_if cmd_if ();

    jk_cmd_driver #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_if    (cmd_if),
        .j         (j),
        .k         (k),
        .ff_reset_ (ff_reset_),
        .q_in      (q_in),
        .busy      (busy),
        .count     (count),
        .mismatch  (mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream JK flip-flop with asynchronous active-low reset.
    always @(posedge clock or negedge ff_reset_) begin
        if (!ff_reset_) begin
            ff_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_in = force_q0 ? 1'b0 : ff_q;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] c;
        logic [1:0] jk;
        logic [4:0] cnt;
        logic       rdy;
        logic       bsy;
        logic       ffr;
        logic       qv;
        logic       q;
    } vec_t;

    vec_t tbl [11];

    task automatic drive(input logic r, input logic v, input logic [1:0] c);
        @(negedge clock);
        reset            = r;
        cmd_if.cmd_valid = v;
        cmd_if.cmd       = c;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [1:0] wcmd [10] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    logic [4:0] ec   [22] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4,
                              5'd3, 5'd4, 5'd3, 5'd3, 5'd2, 5'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0};

    initial begin
        n_pass           = 0;
        n_total          = 0;
        force_q0         = 1'b0;
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = 2'b00;

        // rst v  c      jk     cnt   rdy   bsy   ffr   qv    q
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'b10, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b10, 2'b00, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'b11, 2'b10, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 2'b00, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 2'b11, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 2'b00, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 2'b11, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset for three cycles, then SET, TOGGLE, TOGGLE back to back.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].c);
            chk($sformatf("row%0d_jk", i), int'({j, k}), int'(tbl[i].jk));
            chk($sformatf("row%0d_count", i), int'(count), int'(tbl[i].cnt));
            chk($sformatf("row%0d_ready", i), int'(cmd_if.cmd_ready), int'(tbl[i].rdy));
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("row%0d_ff_reset_", i), int'(ff_reset_), int'(tbl[i].ffr));
            chk($sformatf("row%0d_mismatch", i), int'(mismatch), 0);
            if (tbl[i].qv) begin
                chk($sformatf("row%0d_q", i), int'(ff_q), int'(tbl[i].q));
            end
        end

        // Ten commands offered continuously: fills to 4, blocks, wraps pointers, drains in order.
        begin
            int   acc;
            logic can_push;
            logic v;
            acc = 0;
            for (int e = 1; e <= 22; e++) begin
                can_push = (e == 1) ? 1'b1 : (ec[e-2] != 5'd4);
                v        = (acc < 10);
                drive(1'b0, v, v ? wcmd[acc] : 2'b00);
                if (v && can_push) begin
                    acc++;
                end
                chk($sformatf("wrap_e%0d_count", e), int'(count), int'(ec[e-1]));
                chk($sformatf("wrap_e%0d_ready", e), int'(cmd_if.cmd_ready), (ec[e-1] != 5'd4) ? 1 : 0);
                chk($sformatf("wrap_e%0d_busy", e), int'(busy), (e != 22) ? 1 : 0);
                if ((e % 2 == 0) && (e <= 20)) begin
                    chk($sformatf("wrap_e%0d_jk", e), int'({j, k}), int'(wcmd[e/2-1]));
                end else begin
                    chk($sformatf("wrap_e%0d_jk", e), int'({j, k}), 0);
                end
            end
            chk("wrap_accepted", acc, 10);
            chk("wrap_q", int'(ff_q), 0);
            chk("wrap_mismatch", int'(mismatch), 0);
        end

        // Reset during DRIVE of a SET with three commands still queued.
        drive(1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b1, 2'b10);
        drive(1'b0, 1'b1, 2'b11);
        drive(1'b0, 1'b1, 2'b11);
        drive(1'b0, 1'b1, 2'b10);
        chk("rst_mid_drive_jk", int'({j, k}), 2);
        chk("rst_mid_drive_count", int'(count), 3);
        drive(1'b1, 1'b0, 2'b00);
        chk("rst_mid_jk", int'({j, k}), 0);
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_ready", int'(cmd_if.cmd_ready), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ff_reset_", int'(ff_reset_), 0);
        chk("rst_mid_q", int'(ff_q), 0);
        drive(1'b1, 1'b1, 2'b11);
        chk("rst_hold_count", int'(count), 0);
        chk("rst_hold_ff_reset_", int'(ff_reset_), 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 2'b00);
            chk($sformatf("post_rst%0d_jk", i), int'({j, k}), 0);
            chk($sformatf("post_rst%0d_count", i), int'(count), 0);
            chk($sformatf("post_rst%0d_busy", i), int'(busy), 0);
            chk($sformatf("post_rst%0d_ff_reset_", i), int'(ff_reset_), 1);
        end
        chk("post_rst_q", int'(ff_q), 0);

        // Feed back a wrong q after a SET; the checker latches until reset.
        force_q0 = 1'b1;
        drive(1'b0, 1'b1, 2'b10);
        drive(1'b0, 1'b0, 2'b00);
        chk("mm_drive_jk", int'({j, k}), 2);
        drive(1'b0, 1'b0, 2'b00);
        chk("mm_before_settle_end", int'(mismatch), 0);
        drive(1'b0, 1'b0, 2'b00);
        chk("mm_settle_end", int'(mismatch), int'(EXP_MM));
        force_q0 = 1'b0;
        drive(1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 2'b00);
        chk("mm_sticky", int'(mismatch), int'(EXP_MM));
        drive(1'b1, 1'b0, 2'b00);
        chk("mm_cleared_by_reset", int'(mismatch), 0);
        drive(1'b0, 1'b0, 2'b00);
        chk("mm_after_release", int'(mismatch), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
